five_sec_countdown: RTL and testbench
=====================================

# five_sec_countdown

Down-counter that produces the five-second countdown shown before and between Whack-A-Mole rounds. It runs from the 1 Hz game tick, so one clock edge is one second. It loads a start value in reset, decrements once per clock until it reaches zero, then holds at zero. It also provides an expiry level, a one-cycle done pulse and a seven-segment encoding of the remaining seconds for the display mux.

## Interface
- `START_VALUE`, default 5: value loaded on reset, in seconds (0 to 2^WIDTH-1).
- `WIDTH`, default 32: counter width.
- `clk`  in  1: 1 Hz game tick. All logic is on its rising edge.
- `reset`  in  1: synchronous, active-low reset. 0 at a rising edge reloads the counter.
- `countout`  out  WIDTH: remaining seconds.
- `expired`  out  1: high while `countout` == 0.
- `done`  out  1: one-cycle pulse on the edge where `countout` becomes 0 by counting.
- `seg`  out  7: active-low segments {g,f,e,d,c,b,a} for the value of `countout`.

## Operation
- Reset (`reset`=0 at an edge):
  - `countout` <= START_VALUE.
  - `done` <= 0.
  - Applies on every edge while `reset` is held low, so the counter stays frozen at START_VALUE.
- Counting (`reset`=1):
  - If `countout` != 0, then `countout` <= `countout` - 1.
  - If `countout` == 0, it holds at 0. It never wraps to all-ones.
- `done` is registered. It is 1 for exactly the cycle after the edge that moved `countout` from 1 to 0, and 0 otherwise.
  - It never fires while the counter is held at zero.
  - It never fires directly out of reset, including when START_VALUE=0.
- `expired` is combinational: `countout` == 0. With START_VALUE=0 it is high immediately after reset.
- `seg` is combinational from `countout`:
  - 0 to 9 map to the standard digit patterns. 0 gives 7'b1000000 and 5 gives 7'b0010010.
  - Values above 9 show a dash, 7'b0111111.
- The only way to restart is reset. Asserting reset mid-count reloads START_VALUE on that edge, and `done` is forced to 0.
- Arithmetic is unsigned WIDTH-bit. START_VALUE is truncated to WIDTH.

## Timing
- Outputs after reset: `countout`=5, `expired`=0, `done`=0, `seg`=digit 5.
- Sequence after reset deasserts, by edge:
  - 1st edge: `countout`=4.
  - 2nd edge: 3.
  - 3rd edge: 2.
  - 4th edge: 1.
  - 5th edge: 0. `done`=1 and `expired`=1 for the cycle that follows.
  - 6th edge onward: `countout`=0, `done`=0, `expired`=1.
- Latency: one edge per decrement. Count-to-zero takes START_VALUE edges after release.
- If reset is low on the same edge where `countout` would reach 0, reset wins: the counter reloads and `done` stays 0.
- Reset during expiry reloads START_VALUE on the next edge and clears `expired` combinationally.

## Structure
- Shared package `countdown_pkg`:
  - default START_VALUE (5) and WIDTH (32).
  - seven-segment constants: the DIGIT_0 to DIGIT_9 patterns, SEG_DASH and the active-low polarity note.
- Sub-module `seven_seg_decoder`:
  - input 4-bit value plus an out-of-range flag, output 7-bit `seg`.
  - also reused by the score display.
- Top level holds the counter register, the `done` register and the zero compare.

## Test plan
- Reset: hold `reset`=0 for 3 edges -> `countout`=5 every cycle, `done`=0, `expired`=0, `seg`=7'b0010010.
- Full countdown: release reset, run 7 edges -> `countout` 4,3,2,1,0,0,0. `done` high only after the 5th edge. `expired` high from the 5th edge on. `seg` shows 0 (7'b1000000) at the end.
- Saturation: from 0, run 20 more edges -> `countout` stays 0, never 0xFFFFFFFF, and no further `done`.
- Mid-count reset: at `countout`=2, hold `reset`=0 for one edge -> `countout`=5 and `done`=0. Release -> count resumes at 4.
- Reset on the final edge: at `countout`=1, apply `reset`=0 -> `countout`=5 and no `done` pulse.
- Parameters: START_VALUE=12 gives `seg`=dash until `countout`=9, then digits. START_VALUE=0 gives `expired`=1 right after reset and `done` is never asserted.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared constants for the round countdown and the seven-segment displays.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}: a 0 lights the segment.
package countdown_pkg;

  localparam int unsigned DEFAULT_START_VALUE = 5;
  localparam int unsigned DEFAULT_WIDTH       = 32;

  localparam logic [6:0] DIGIT_0  = 7'b1000000;
  localparam logic [6:0] DIGIT_1  = 7'b1111001;
  localparam logic [6:0] DIGIT_2  = 7'b0100100;
  localparam logic [6:0] DIGIT_3  = 7'b0110000;
  localparam logic [6:0] DIGIT_4  = 7'b0011001;
  localparam logic [6:0] DIGIT_5  = 7'b0010010;
  localparam logic [6:0] DIGIT_6  = 7'b0000010;
  localparam logic [6:0] DIGIT_7  = 7'b1111000;
  localparam logic [6:0] DIGIT_8  = 7'b0000000;
  localparam logic [6:0] DIGIT_9  = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Codes 10..15 have no decimal glyph and fall back to the dash.
  function automatic logic [6:0] seg_pattern(input logic [3:0] value);
    logic [6:0] pat;
    pat = SEG_DASH;
    case (value)
      4'd0: pat = DIGIT_0;
      4'd1: pat = DIGIT_1;
      4'd2: pat = DIGIT_2;
      4'd3: pat = DIGIT_3;
      4'd4: pat = DIGIT_4;
      4'd5: pat = DIGIT_5;
      4'd6: pat = DIGIT_6;
      4'd7: pat = DIGIT_7;
      4'd8: pat = DIGIT_8;
      4'd9: pat = DIGIT_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Single-digit active-low seven-segment decoder; also used by the score display.
// The out-of-range flag lets callers with wider values force the dash.
module seven_seg_decoder
  import countdown_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       oor_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (!oor_i) begin
      seg_o = seg_pattern(value_i);
    end
  end

endmodule

// File: rtl/five_sec_countdown.sv
// Saturating down-counter for the pre-round countdown, clocked by the 1 Hz game tick.
// Reloads START_VALUE under active-low sync reset, stops at zero, pulses done on arrival.
module five_sec_countdown
  import countdown_pkg::*;
#(
  parameter int unsigned START_VALUE = DEFAULT_START_VALUE,
  parameter int unsigned WIDTH       = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] countout,
  output logic             expired,
  output logic             done,
  output logic [6:0]       seg
);

  localparam logic [WIDTH-1:0] START_W = WIDTH'(START_VALUE);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [WIDTH-1:0] NINE_W  = WIDTH'(9);

  logic [WIDTH-1:0] countout_q, countout_d;
  logic             done_q, done_d;
  logic             at_zero;
  logic             seg_oor;
  logic [3:0]       seg_digit;

  assign at_zero = (countout_q == '0);

  always_comb begin
    countout_d = countout_q;
    done_d     = 1'b0;
    if (!reset) begin
      countout_d = START_W;
    end else if (!at_zero) begin
      countout_d = countout_q - ONE_W;
      // Only a real 1 -> 0 step pulses; holding at zero or reloading never does.
      done_d     = (countout_q == ONE_W);
    end
  end

  always_ff @(posedge clk) begin
    countout_q <= countout_d;
    done_q     <= done_d;
  end

  assign seg_oor   = (countout_q > NINE_W);
  assign seg_digit = 4'(countout_q);

  seven_seg_decoder u_seg (
    .value_i (seg_digit),
    .oor_i   (seg_oor),
    .seg_o   (seg)
  );

  assign countout = countout_q;
  assign expired  = at_zero;
  assign done     = done_q;

endmodule

// File: tb/tb_five_sec_countdown.sv
// Bench for five_sec_countdown: three instances (START_VALUE 5, 12, 0) against an
// elapsed-seconds reference model, directed scenarios followed by random reset traffic.
module tb_five_sec_countdown;

  logic        clk;
  logic [2:0]  rst_n;
  logic [31:0] cnt0, cnt1, cnt2;
  logic [2:0]  exp_o, done_o;
  logic [6:0]  seg0, seg1, seg2;

  int unsigned n_cmp;
  int unsigned n_err;

  int unsigned start_v [3] = '{5, 12, 0};
  int unsigned elapsed [3];
  bit          done_m  [3];

  logic [6:0] digit_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
  logic [6:0] dash = 7'b0111111;

  five_sec_countdown #(.START_VALUE(5), .WIDTH(32)) u_d5 (
    .clk(clk), .reset(rst_n[0]), .countout(cnt0), .expired(exp_o[0]),
    .done(done_o[0]), .seg(seg0));
  five_sec_countdown #(.START_VALUE(12), .WIDTH(32)) u_d12 (
    .clk(clk), .reset(rst_n[1]), .countout(cnt1), .expired(exp_o[1]),
    .done(done_o[1]), .seg(seg1));
  five_sec_countdown #(.START_VALUE(0), .WIDTH(32)) u_d0 (
    .clk(clk), .reset(rst_n[2]), .countout(cnt2), .expired(exp_o[2]),
    .done(done_o[2]), .seg(seg2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int unsigned model_count(input int i);
    return (elapsed[i] >= start_v[i]) ? 0 : start_v[i] - elapsed[i];
  endfunction

  function automatic logic [6:0] model_seg(input int unsigned v);
    return (v <= 9) ? digit_tbl[v] : dash;
  endfunction

  task automatic check_inst(input int i, input logic [31:0] c, input logic e,
                            input logic d, input logic [6:0] s);
    int unsigned mc;
    mc = model_count(i);
    chk($sformatf("cnt[%0d]", i),  c, mc);
    chk($sformatf("exp[%0d]", i),  {31'd0, e}, {31'd0, (mc == 0)});
    chk($sformatf("done[%0d]", i), {31'd0, d}, {31'd0, done_m[i]});
    chk($sformatf("seg[%0d]", i),  {25'd0, s}, {25'd0, model_seg(mc)});
  endtask

  // One tick: apply resets, advance the model, then check mid-cycle.
  task automatic step(input logic [2:0] r);
    rst_n = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!r[i]) begin
        elapsed[i] = 0;
        done_m[i]  = 1'b0;
      end else begin
        if (elapsed[i] < 1000) elapsed[i]++;
        done_m[i] = (start_v[i] > 0) && (elapsed[i] == start_v[i]);
      end
    end
    @(negedge clk);
    check_inst(0, cnt0, exp_o[0], done_o[0], seg0);
    check_inst(1, cnt1, exp_o[1], done_o[1], seg1);
    check_inst(2, cnt2, exp_o[2], done_o[2], seg2);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 3'b000;
    for (int i = 0; i < 3; i++) begin
      elapsed[i] = 0;
      done_m[i]  = 1'b0;
    end
    @(negedge clk);

    // Reset hold, then full countdown and saturation.
    repeat (3) step(3'b000);
    chk("seg5_reset", {25'd0, seg0}, 32'h12);
    repeat (7) step(3'b111);
    chk("seg0_end", {25'd0, seg0}, 32'h40);
    repeat (20) step(3'b111);
    chk("sat_no_wrap", cnt0, 32'd0);

    // Mid-count reset at 2, then resume.
    step(3'b000);
    repeat (3) step(3'b111);
    chk("at_two", cnt0, 32'd2);
    step(3'b110);
    chk("mid_reload", cnt0, 32'd5);
    step(3'b111);
    chk("resume", cnt0, 32'd4);

    // Reset on the edge that would reach zero.
    step(3'b000);
    repeat (4) step(3'b111);
    chk("at_one", cnt0, 32'd1);
    step(3'b110);
    chk("last_edge_reload", cnt0, 32'd5);
    chk("last_edge_nodone", {31'd0, done_o[0]}, 32'd0);

    // Random reset traffic, each instance independent.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] r;
      for (int i = 0; i < 3; i++) r[i] = ($urandom_range(0, 9) != 0);
      step(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
